// File: rtl/bin2bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared calculator definitions for the sequential binary-to-BCD converter.
//   CALC_WIDTH  : binary operand width (32 is the only supported value)
//   CALC_DIGITS : number of packed BCD digits produced (10)
//   CNT_W       : width of the shift counter, wide enough to hold CALC_WIDTH
//   state_e     : converter FSM states
//   bcd_digit_t : a single 4-bit BCD digit
//   add3        : double-dabble digit correction
// ---------------------------------------------------------------------------
package bin2bcd_seq_pkg;

  localparam int CALC_WIDTH  = 32;
  localparam int CALC_DIGITS = 10;
  localparam int CNT_W       = $clog2(CALC_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // A digit of 5 or more would overflow past 9 once doubled by the next shift,
  // so it is pre-biased by 3 to carry correctly into the next decimal place.
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_complement32.sv
// ---------------------------------------------------------------------------
// complement32
// Two's complement negation of a 32-bit value.
//   a_i : value to negate
//   y_o : -a_i modulo 2^32 (0x80000000 maps to itself)
// ---------------------------------------------------------------------------
module complement32 (
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);

  assign y_o = ~a_i + 32'd1;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential signed/unsigned binary to packed BCD converter using the
// shift-add-3 (double dabble) algorithm, one input bit per clock.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data / in_signed valid
//   in_ready  : converter idle and able to accept
//   in_data   : binary value to convert
//   in_signed : 1 = interpret in_data as two's complement
//   out_valid : conversion result available
//   out_ready : consumer takes the result
//   out_neg   : result is negative
//   out_bcd   : packed BCD, digit 0 in [3:0], most significant digit on top
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_neg,
  output logic [4*DIGITS-1:0]   out_bcd
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;

  logic [WIDTH-1:0]     negData;
  logic [4*DIGITS-1:0]  bcdAdj;
  logic                 acceptNeg;

  // Negation reuses the shared complement block; the most negative input
  // comes back unchanged and is then treated as an unsigned magnitude.
  complement32 u_complement32 (
    .a_i (in_data),
    .y_o (negData)
  );

  assign acceptNeg = in_signed & in_data[WIDTH-1];

  // Per-digit add-3 correction applied before every shift.
  always_comb begin
    bcdAdj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcdAdj[i*4 +: 4] = add3(bcd_q[i*4 +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d   = acceptNeg;
          mag_d   = acceptNeg ? negData : in_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // {bcd, mag} shifts left as one long register; the MSB of the
        // magnitude enters digit 0.
        bcd_d = {bcdAdj[4*DIGITS-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // No bypass: in_ready only rises once IDLE is reached.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_neg   = neg_q;
  assign out_bcd   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq: table of known conversions, a few
// model-checked random values, backpressure, in_valid noise during shifting,
// and reset in the middle of a conversion.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic        out_neg;
   logic [39:0] out_bcd;

   int checks;
   int failures;

   typedef struct {
      logic        neg;
      logic [39:0] bcd;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      logic        sgn;
      logic        neg;
      logic [39:0] bcd;
   } vec_t;

   exp_t sbQ[$];
   vec_t vecs[11];

   bin2bcd_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_neg   (out_neg),
      .out_bcd   (out_bcd)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Independent reference: signed/unsigned magnitude and decimal digits by division.
   function automatic exp_t modelConvert(input logic [31:0] d, input logic s);
      exp_t e;
      longint unsigned m;
      e.neg = s && d[31];
      m = e.neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
      e.bcd = '0;
      for (int i = 0; i < 10; i++) begin
         e.bcd[i*4 +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return e;
   endfunction

   // Hand one value to the converter, push its expectation, and wait (bounded)
   // for out_valid, checking the 32-cycle latency. Optionally wiggles
   // in_valid/in_data while the conversion is running.
   task automatic applyStimulus(input string name, input logic [31:0] d, input logic s,
                                input exp_t e, input bit noise);
      int lat;
      checkOutput({name, " in_ready before"}, {63'd0, in_ready}, 64'd1);
      in_data   = d;
      in_signed = s;
      in_valid  = 1'b1;
      sbQ.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (noise) begin
            in_valid  = ~in_valid;
            in_data   = $urandom;
            in_signed = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      checkOutput({name, " latency"}, 64'(lat), 64'd32);
   endtask

   // Pop the scoreboard and compare against what the DUT is presenting.
   task automatic popAndCheck(input string name);
      exp_t e;
      checkOutput({name, " out_valid"}, {63'd0, out_valid}, 64'd1);
      if (sbQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: scoreboard empty, got bcd 0x%0h", name, out_bcd);
      end else begin
         e = sbQ.pop_front();
         checkOutput({name, " out_neg"}, {63'd0, out_neg}, {63'd0, e.neg});
         checkOutput({name, " out_bcd"}, {24'd0, out_bcd}, {24'd0, e.bcd});
      end
   endtask

   // Consume the result with a one-cycle out_ready pulse.
   task automatic releaseOutput(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({name, " out_valid after take"}, {63'd0, out_valid}, 64'd0);
      checkOutput({name, " in_ready after take"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      exp_t e;
      logic [39:0] heldBcd;
      logic        heldNeg;
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_signed = 1'b0;
      out_ready = 1'b0;

      vecs[0]  = '{32'h00000EFF, 1'b0, 1'b0, 40'h0000003839};
      vecs[1]  = '{32'h00000234, 1'b1, 1'b0, 40'h0000000564};
      vecs[2]  = '{32'hFFFFF101, 1'b1, 1'b1, 40'h0000003839};
      vecs[3]  = '{32'hFFFFF101, 1'b0, 1'b0, 40'h4294963457};
      vecs[4]  = '{32'hFFFFFFFF, 1'b0, 1'b0, 40'h4294967295};
      vecs[5]  = '{32'h80000000, 1'b1, 1'b1, 40'h2147483648};
      vecs[6]  = '{32'h00000000, 1'b1, 1'b0, 40'h0000000000};
      vecs[7]  = '{32'h00000000, 1'b0, 1'b0, 40'h0000000000};
      vecs[8]  = '{32'h7FFFFFFF, 1'b1, 1'b0, 40'h2147483647};
      vecs[9]  = '{32'hFFFFFFFF, 1'b1, 1'b1, 40'h0000000001};
      vecs[10] = '{32'h80000000, 1'b0, 1'b0, 40'h2147483648};

      // Reset values while rst_n is held low.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset out_neg", {63'd0, out_neg}, 64'd0);
      checkOutput("reset out_bcd", {24'd0, out_bcd}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table of known conversions.
      for (int i = 0; i < 11; i++) begin
         e.neg = vecs[i].neg;
         e.bcd = vecs[i].bcd;
         applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].sgn, e, 1'b0);
         popAndCheck($sformatf("vec%0d", i));
         releaseOutput($sformatf("vec%0d", i));
      end

      // Random values against the division model.
      for (int i = 0; i < 4; i++) begin
         logic [31:0] d;
         logic        s;
         d = $urandom;
         s = 1'(i % 2);
         applyStimulus($sformatf("rand%0d", i), d, s, modelConvert(d, s), 1'b0);
         popAndCheck($sformatf("rand%0d", i));
         releaseOutput($sformatf("rand%0d", i));
      end

      // Backpressure: result and flags must hold while out_ready stays low.
      e.neg = 1'b1;
      e.bcd = 40'h0000012345;
      applyStimulus("bp", 32'hFFFFCFC7, 1'b1, e, 1'b0);
      heldBcd = out_bcd;
      heldNeg = out_neg;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("bp hold%0d out_valid", c), {63'd0, out_valid}, 64'd1);
         checkOutput($sformatf("bp hold%0d in_ready", c), {63'd0, in_ready}, 64'd0);
         checkOutput($sformatf("bp hold%0d out_bcd", c), {24'd0, out_bcd}, {24'd0, heldBcd});
         checkOutput($sformatf("bp hold%0d out_neg", c), {63'd0, out_neg}, {63'd0, heldNeg});
      end
      popAndCheck("bp");
      releaseOutput("bp");

      // in_valid noise while shifting must not disturb the result.
      e.neg = 1'b0;
      e.bcd = 40'h0000987654;
      applyStimulus("noise", 32'h000F1206, 1'b0, e, 1'b1);
      popAndCheck("noise");
      releaseOutput("noise");

      // Reset in the middle of shifting aborts with nothing flagged valid.
      in_data   = 32'hFFFFFFFF;
      in_signed = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("midrst in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("midrst out_bcd", {24'd0, out_bcd}, 64'd0);
      checkOutput("midrst out_neg", {63'd0, out_neg}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      e.neg = 1'b0;
      e.bcd = 40'h0000000018;
      applyStimulus("postrst", 32'h00000012, 1'b0, e, 1'b0);
      popAndCheck("postrst");
      releaseOutput("postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential signed/unsigned 32-bit binary to BCD converter. It sits directly downstream of the ALU result path and its complement32 negation stage, and feeds the calculator's decimal display. It takes a 32-bit result and produces a sign flag plus 10 packed BCD digits, using iterative shift-add-3 (double dabble), one bit per clock. Valid/ready handshake on both sides.

Parameters:
WIDTH, 32, binary input width; the only supported value.
DIGITS, 10, BCD digit count; must be at least ceil(WIDTH*log10(2)).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data/in_signed valid
in_ready  output  1  converter idle, can accept
in_data  input  WIDTH  binary value to convert
in_signed  input  1  1 = treat in_data as two's complement
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_neg  output  1  result negative
out_bcd  output  4*DIGITS  packed BCD; digit 0 in [3:0], most significant digit in [39:36]

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_neg=0, out_bcd=0, internal magnitude and counter=0.
- FSM states: IDLE, SHIFT, DONE. in_ready=(state==IDLE). out_valid=(state==DONE).
- IDLE, on an edge with in_valid&&in_ready:
  - neg=in_signed&in_data[31].
  - mag = neg ? complement32(in_data) : in_data.
  - bcd=0, cnt=WIDTH, go to SHIFT.
  - in_valid while not in IDLE is ignored.
- SHIFT, each cycle:
  - Every 4-bit digit >=5 gets +3 (combinational).
  - Then {bcd,mag} shifts left by 1; cnt decrements.
  - After the WIDTH-th shift, go to DONE.
- Latency: acceptance on edge E0; shifts on E1..E32; out_valid is high after E32. That is 32 cycles from acceptance to valid, and one conversion per at least 34 cycles.
- DONE: out_bcd/out_neg held stable while out_valid && !out_ready, for any number of cycles.
  - On an edge with out_ready: go to IDLE.
  - in_ready rises the next cycle; there is no same-cycle accept (no bypass).
- out_bcd is the internal BCD register and is meaningful only while out_valid=1. out_neg updates at acceptance.
- Arithmetic rules:
  - The magnitude is unsigned 32-bit. 0x80000000 signed gives neg=1 and magnitude 2147483648; complement32 returns 0x80000000, which is read as unsigned.
  - Max unsigned 4294967295 needs all 10 digits; no overflow is possible.
  - Zero gives neg=0; negative zero is impossible.
- rst_n assertion mid-SHIFT or in DONE aborts immediately to the reset values. No partial result is ever flagged valid.

Decomposition:
- Shared calc package: WIDTH=32, DIGITS=10, FSM state enum (IDLE/SHIFT/DONE, 2-bit encoding), and a BCD digit typedef (4-bit).
- Sub-module: instantiate the existing complement32 for negation; do not re-implement it.
- The per-digit add-3 correction is a function or generate loop, not a separate module.

Test Plan:
- Unsigned 0x00000EFF -> after 32 cycles: out_valid=1, out_neg=0, out_bcd=40'h0000003839.
- Signed 0x00000234 -> out_neg=0, out_bcd=40'h0000000564.
- Signed 0xFFFFF101 (-3839) -> out_neg=1, out_bcd=40'h0000003839. The same value unsigned -> out_neg=0, out_bcd=40'h4294963457.
- Boundaries:
  - Unsigned 0xFFFFFFFF -> 40'h4294967295, neg=0.
  - Signed 0x80000000 -> neg=1, 40'h2147483648.
  - 0x00000000 -> 40'h0, neg=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Pulse out_ready -> out_valid=0 and in_ready=1 next cycle. Toggle in_valid during SHIFT -> no effect on the result.
- Reset mid-conversion: assert rst_n=0 at shift cycle 10 -> out_valid=0, in_ready=1, out_bcd=0 immediately. After release, a new conversion of 0x12 -> 40'h18, neg=0.
